// File: rtl/wb_periph_decoder_if.sv
// wb_periph_decoder_if: master-side and slave-side Wishbone signals of the peripheral decoder.
// The slave modport is the decoder's view; the master modport is the surrounding SoC/bench view.
interface wb_periph_decoder_if #(
  parameter int NUM_SLAVES = 4,
  parameter int ADDR_W = 32
);
  logic                    wbm_cyc_i;
  logic                    wbm_stb_i;
  logic                    wbm_we_i;
  logic [3:0]              wbm_sel_i;
  logic [ADDR_W-1:0]       wbm_adr_i;
  logic [31:0]             wbm_dat_i;
  logic                    wbm_ack_o;
  logic [31:0]             wbm_dat_o;
  logic [NUM_SLAVES-1:0]   wbs_cyc_o;
  logic [NUM_SLAVES-1:0]   wbs_stb_o;
  logic                    wbs_we_o;
  logic [3:0]              wbs_sel_o;
  logic [ADDR_W-1:0]       wbs_adr_o;
  logic [31:0]             wbs_dat_o;
  logic [NUM_SLAVES-1:0]   wbs_ack_i;
  logic [32*NUM_SLAVES-1:0] wbs_dat_i;
  modport slave (
    input  wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i, wbs_ack_i, wbs_dat_i,
    output wbm_ack_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
  );
  modport master (
    output wbm_cyc_i, wbm_stb_i, wbm_we_i, wbm_sel_i, wbm_adr_i, wbm_dat_i, wbs_ack_i, wbs_dat_i,
    input  wbm_ack_o, wbm_dat_o, wbs_cyc_o, wbs_stb_o, wbs_we_o, wbs_sel_o, wbs_adr_o, wbs_dat_o
  );
endinterface

// File: rtl/wb_periph_decoder.sv
// wb_periph_decoder: one Wishbone master to NUM_SLAVES peripherals with an internal default slave.
// Define WB_DEC_TIMEOUT_EN to compile in the no-ack watchdog.
module wb_periph_decoder #(
  parameter int              NUM_SLAVES     = 4,
  parameter int              ADDR_W         = 32,
  parameter int              SEL_LSB        = 8,
  parameter int              SEL_W          = 12,
  parameter logic [SEL_W-1:0] BASE_SEL      = 12'hE00,
  parameter logic [31:0]     DEFAULT_DATA   = 32'hDEAD_BEEF,
  parameter int              TIMEOUT_CYCLES = 16,
  parameter logic [31:0]     TIMEOUT_DATA   = 32'hBADC_0DE0
) (
  input  logic               clk,
  input  logic               rst_n,
  wb_periph_decoder_if.slave bus,
  output logic               timeout_o,
  output logic [7:0]         err_cnt_o
);
  localparam int IW = NUM_SLAVES > 1 ? $clog2(NUM_SLAVES) : 1;
  typedef enum logic [1:0] {IDLE, ACTIVE, DFLT, RESP} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [NUM_SLAVES-1:0] stb_q, stb_d;
  logic                  we_q, we_d;
  logic [3:0]            sel_q, sel_d;
  logic [ADDR_W-1:0]     adr_q, adr_d;
  logic [31:0]           wdat_q, wdat_d;
  logic [31:0]           rdat_q, rdat_d;
  logic                  ack_q, ack_d;
  logic [7:0]            err_q, err_d;
  logic [SEL_W-1:0]      diff;
  logic                  req, hit, sack;
  logic [31:0]           sdat;
  logic [7:0]            err_inc;
`ifdef WB_DEC_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic                  to_q, to_d;
`endif
  assign req     = bus.wbm_cyc_i & bus.wbm_stb_i;
  assign diff    = bus.wbm_adr_i[SEL_LSB +: SEL_W] - BASE_SEL;
  assign hit     = diff < SEL_W'(NUM_SLAVES);
  assign sack    = bus.wbs_ack_i[idx_q];
  assign sdat    = bus.wbs_dat_i[idx_q*32 +: 32];
  assign err_inc = err_q + {7'd0, err_q != 8'hFF};
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    stb_d   = stb_q;
    we_d    = we_q;
    sel_d   = sel_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    rdat_d  = rdat_q;
    ack_d   = 1'b0;
    err_d   = err_q;
`ifdef WB_DEC_TIMEOUT_EN
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    to_d    = 1'b0;
`endif
    case (state_q)
      IDLE: if (req) begin
        we_d   = bus.wbm_we_i;
        sel_d  = bus.wbm_sel_i;
        adr_d  = bus.wbm_adr_i;
        wdat_d = bus.wbm_dat_i;
        if (hit) begin
          idx_d   = diff[IW-1:0];
          stb_d   = NUM_SLAVES'(1) << diff[IW-1:0];
          state_d = ACTIVE;
`ifdef WB_DEC_TIMEOUT_EN
          cnt_d   = '0;
          pend_d  = 1'b0;
`endif
        end else begin
          ack_d   = 1'b1;
          rdat_d  = DEFAULT_DATA;
          err_d   = err_inc;
          state_d = DFLT;
        end
      end
      ACTIVE: begin
        if (!bus.wbm_cyc_i) begin
          stb_d   = '0;
          state_d = IDLE;
        end
`ifdef WB_DEC_TIMEOUT_EN
        else if (pend_q) begin
          ack_d   = 1'b1;
          rdat_d  = TIMEOUT_DATA;
          to_d    = 1'b1;
          err_d   = err_inc;
          state_d = RESP;
        end
`endif
        else if (sack) begin
          ack_d   = 1'b1;
          rdat_d  = sdat;
          stb_d   = '0;
          state_d = RESP;
        end
`ifdef WB_DEC_TIMEOUT_EN
        else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
          stb_d  = '0;
          pend_d = 1'b1;
        end else cnt_d = cnt_q + 1'b1;
`endif
      end
      DFLT:    state_d = bus.wbm_cyc_i ? RESP : IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      stb_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= '0;
`ifdef WB_DEC_TIMEOUT_EN
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      to_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      rdat_q  <= rdat_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
`ifdef WB_DEC_TIMEOUT_EN
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      to_q    <= to_d;
`endif
    end
  end
  assign bus.wbm_ack_o = ack_q;
  assign bus.wbm_dat_o = rdat_q;
  assign bus.wbs_cyc_o = stb_q;
  assign bus.wbs_stb_o = stb_q;
  assign bus.wbs_we_o  = we_q;
  assign bus.wbs_sel_o = sel_q;
  assign bus.wbs_adr_o = adr_q;
  assign bus.wbs_dat_o = wdat_q;
  assign err_cnt_o     = err_q;
`ifdef WB_DEC_TIMEOUT_EN
  assign timeout_o     = to_q;
`else
  assign timeout_o     = 1'b0;
`endif
endmodule

// File: tb/tb_wb_periph_decoder.sv
// tb_wb_periph_decoder: vector table plus scoreboard for wb_periph_decoder with four model slaves.
// Slave k answers 32'hCAFE_000k after a per-transfer ack delay.
module tb_wb_periph_decoder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       to;
  logic [7:0] err;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         err_m = 0;
  int         dly [4];
  logic [15:0] scnt [4];
  typedef struct {
    logic [31:0] adr;
    logic        we;
    logic [31:0] wdat;
    int          dly;
    logic [3:0]  mask;
    int          ackc;
    int          stbc;
    logic [31:0] dat;
    logic        to;
    logic        inc;
  } vec_t;
  typedef struct {
    logic [31:0] dat;
    int          ackc;
    int          stbc;
    logic [3:0]  mask;
    logic        to;
    int          err;
    logic        we;
    logic [31:0] wdat;
  } exp_t;
  exp_t sb [$];
  vec_t tbl [$];
  wb_periph_decoder_if #(.NUM_SLAVES(4), .ADDR_W(32)) bus ();
  wb_periph_decoder dut (.clk(clk), .rst_n(rst_n), .bus(bus), .timeout_o(to), .err_cnt_o(err));
  always #5 clk = ~clk;
  always_ff @(posedge clk)
    for (int k = 0; k < 4; k++) scnt[k] <= bus.wbs_stb_o[k] ? scnt[k] + 16'd1 : 16'd0;
  for (genvar g = 0; g < 4; g++) begin : g_slv
    assign bus.wbs_ack_i[g] = bus.wbs_stb_o[g] && (int'(scnt[g]) == dly[g]);
    assign bus.wbs_dat_i[32*g +: 32] = 32'hCAFE_0000 | g;
  end
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, a, e);
    end
  endtask
  task automatic xfer(input vec_t v);
    exp_t        e;
    int          c = 0;
    int          stbc = 0;
    int          ackc = 0;
    logic        got = 1'b0;
    logic        tos = 1'b0;
    logic [3:0]  m1 = '0;
    logic        we1 = 1'b0;
    logic [31:0] wd1 = '0;
    logic [31:0] ad = '0;
    logic [7:0]  ae = '0;
    if (v.inc && err_m < 255) err_m++;
    sb.push_back('{v.dat, v.ackc, v.stbc, v.mask, v.to, err_m, v.we, v.wdat});
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) dly[k] = v.dly;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_we_i  = v.we;
    bus.wbm_sel_i = 4'hF;
    bus.wbm_adr_i = v.adr;
    bus.wbm_dat_i = v.wdat;
    while (!got && c < 100) begin
      @(posedge clk);
      #1;
      c++;
      if (c == 1) begin
        m1  = bus.wbs_stb_o;
        we1 = bus.wbs_we_o;
        wd1 = bus.wbs_dat_o;
      end
      if (|bus.wbs_stb_o) stbc++;
      if (to) tos = 1'b1;
      if (bus.wbm_ack_o) begin
        got  = 1'b1;
        ackc = c;
        ad   = bus.wbm_dat_o;
        ae   = err;
        bus.wbm_cyc_i = 1'b0;
        bus.wbm_stb_i = 1'b0;
      end
    end
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    e = sb.pop_front();
    chk("stb_mask_c1", {28'd0, m1}, {28'd0, e.mask});
    chk("wbs_we_c1", {31'd0, we1}, {31'd0, e.we});
    chk("wbs_dat_c1", wd1, e.wdat);
    if (!got) chk("ack_seen", 32'd0, 32'd1);
    else begin
      chk("ack_cycle", ackc, e.ackc);
      chk("stb_cycles", stbc, e.stbc);
      chk("rdata", ad, e.dat);
      chk("timeout", {31'd0, tos}, {31'd0, e.to});
      chk("err_cnt", {24'd0, ae}, e.err);
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no end expected finish");
    $fatal(1, "bench timed out");
  end
  initial begin
    vec_t u;
    logic sawack;
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    bus.wbm_we_i  = 1'b0;
    bus.wbm_sel_i = '0;
    bus.wbm_adr_i = '0;
    bus.wbm_dat_i = '0;
    for (int k = 0; k < 4; k++) dly[k] = 0;
    tbl.push_back('{32'h000E_0000, 1'b1, 32'h1234_5678, 2, 4'b0001, 4, 3, 32'hCAFE_0000, 1'b0, 1'b0});
    tbl.push_back('{32'h000E_0204, 1'b0, 32'h0000_1111, 0, 4'b0100, 2, 1, 32'hCAFE_0002, 1'b0, 1'b0});
    tbl.push_back('{32'h000E_0400, 1'b0, 32'h0000_2222, 0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1});
    tbl.push_back('{32'h0008_E000, 1'b1, 32'h0000_3333, 0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1});
    tbl.push_back('{32'h000E_03FC, 1'b0, 32'h0000_4444, 1, 4'b1000, 3, 2, 32'hCAFE_0003, 1'b0, 1'b0});
    tbl.push_back('{32'h000E_0100, 1'b1, 32'hA5A5_5A5A, 5, 4'b0010, 7, 6, 32'hCAFE_0001, 1'b0, 1'b0});
    tbl.push_back('{32'h000D_FF00, 1'b0, 32'h0000_5555, 0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1});
    tbl.push_back('{32'hFF0E_0100, 1'b0, 32'h0000_6666, 0, 4'b0010, 2, 1, 32'hCAFE_0001, 1'b0, 1'b0});
`ifdef WB_DEC_TIMEOUT_EN
    tbl.push_back('{32'h000E_0100, 1'b0, 32'h0000_7777, 1000, 4'b0010, 18, 16, 32'hBADC_0DE0, 1'b1, 1'b1});
    tbl.push_back('{32'h000E_0200, 1'b0, 32'h0000_8888, 15, 4'b0100, 17, 16, 32'hCAFE_0002, 1'b0, 1'b0});
    tbl.push_back('{32'h000E_0300, 1'b0, 32'h0000_9999, 16, 4'b1000, 18, 16, 32'hBADC_0DE0, 1'b1, 1'b1});
    tbl.push_back('{32'h000E_0000, 1'b0, 32'h0000_AAAA, 14, 4'b0001, 16, 15, 32'hCAFE_0000, 1'b0, 1'b0});
`endif
    #12;
    chk("rst_ack", {31'd0, bus.wbm_ack_o}, 32'd0);
    chk("rst_stb", {28'd0, bus.wbs_stb_o}, 32'd0);
    chk("rst_cyc", {28'd0, bus.wbs_cyc_o}, 32'd0);
    chk("rst_dat", bus.wbm_dat_o, 32'd0);
    chk("rst_err", {24'd0, err}, 32'd0);
    chk("rst_to", {31'd0, to}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    foreach (tbl[i]) xfer(tbl[i]);
    repeat (3) @(negedge clk);
    dly[1] = 1000;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_we_i  = 1'b0;
    bus.wbm_adr_i = 32'h000E_0100;
    @(posedge clk); #1;
    chk("abort_stb_c1", {28'd0, bus.wbs_stb_o}, 32'h2);
    @(posedge clk); #1;
    bus.wbm_adr_i = 32'h000E_0400;
    chk("abort_stb_c2", {28'd0, bus.wbs_stb_o}, 32'h2);
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("abort_stb_c3", {28'd0, bus.wbs_stb_o}, 32'd0);
    chk("abort_ack_c3", {31'd0, bus.wbm_ack_o}, 32'd0);
    @(posedge clk); #1;
    chk("abort_ack_c4", {31'd0, bus.wbm_ack_o}, 32'd0);
    chk("abort_err", {24'd0, err}, err_m);
    xfer('{32'h000E_0204, 1'b0, 32'h0000_BBBB, 0, 4'b0100, 2, 1, 32'hCAFE_0002, 1'b0, 1'b0});
`ifndef WB_DEC_TIMEOUT_EN
    repeat (3) @(negedge clk);
    dly[3] = 1000;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_adr_i = 32'h000E_0300;
    sawack = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.wbm_ack_o || to || bus.wbs_stb_o != 4'b1000) sawack = 1'b1;
    end
    chk("stall_no_ack", {31'd0, sawack}, 32'd0);
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    @(posedge clk); #1;
    chk("stall_abort_stb", {28'd0, bus.wbs_stb_o}, 32'd0);
`endif
    u = '{32'h000E_0F00, 1'b0, 32'h0, 0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1};
    for (int i = 0; i < 300; i++) xfer(u);
    chk("sat_err", {24'd0, err}, 32'd255);
    repeat (3) @(negedge clk);
    dly[0] = 1000;
    bus.wbm_cyc_i = 1'b1;
    bus.wbm_stb_i = 1'b1;
    bus.wbm_adr_i = 32'h000E_0000;
    @(posedge clk); #1;
    chk("arst_stb_before", {28'd0, bus.wbs_stb_o}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stb", {28'd0, bus.wbs_stb_o}, 32'd0);
    chk("arst_cyc", {28'd0, bus.wbs_cyc_o}, 32'd0);
    chk("arst_err", {24'd0, err}, 32'd0);
    bus.wbm_cyc_i = 1'b0;
    bus.wbm_stb_i = 1'b0;
    err_m = 0;
    @(negedge clk);
    rst_n = 1'b1;
    xfer('{32'h000E_0300, 1'b1, 32'hFEED_F00D, 0, 4'b1000, 2, 1, 32'hCAFE_0003, 1'b0, 1'b0});
    xfer('{32'h000E_0500, 1'b0, 32'h0000_CCCC, 0, 4'b0000, 1, 0, 32'hDEAD_BEEF, 1'b0, 1'b1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
